// File: rtl/mcu_pkg.sv
// ============================================================================
// Module  : mcu_pkg
// Brief   : Shared state, mode and LFSR constants for the playlist controller.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

package mcu_pkg;

  localparam logic [2:0] RESET = 3'd0;
  localparam logic [2:0] PAUSE = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] PLAY  = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  typedef enum logic [2:0] {
    S_RESET = RESET,
    S_PAUSE = PAUSE,
    S_LOAD  = LOAD,
    S_PLAY  = PLAY,
    S_STOP  = STOP
  } state_e;

  localparam logic [1:0] MODE_ONCE       = 2'b00;
  localparam logic [1:0] MODE_REPEAT_ALL = 2'b01;
  localparam logic [1:0] MODE_REPEAT_ONE = 2'b10;
  localparam logic [1:0] MODE_SINGLE     = 2'b11;

  // Fibonacci taps 8,6,5,4 expressed as a mask over bits [7:0]
  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

`default_nettype wire

// File: rtl/mcu_lfsr8.sv
// ============================================================================
// Module  : mcu_lfsr8
// Brief   : Free-running 8-bit Fibonacci LFSR with asynchronous reset.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_lfsr8
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  output logic [7:0] lfsr
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[6:0], ^(lfsr & LFSR_TAPS)};
    end
  end

endmodule

`default_nettype wire

// File: rtl/mcu_playlist_ctrl.sv
// ============================================================================
// Module  : mcu_playlist_ctrl
// Brief   : Playlist player control FSM (play/pause, skip, end-of-track modes).
//           Optional shuffle enabled by defining MCU_PLAYLIST_SHUFFLE_EN.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module mcu_playlist_ctrl
  import mcu_pkg::*;
#(
  parameter  int NUM_SONGS = 4,
  localparam int SONG_W    = $clog2(NUM_SONGS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play_pause,
  input  logic              next,
  input  logic              prev,
  input  logic              song_done,
`ifdef MCU_PLAYLIST_SHUFFLE_EN
  input  logic              shuffle,
`endif
  input  logic [1:0]        mode,
  output logic              play,
  output logic              reset_play,
  output logic              next_song,
  output logic [SONG_W-1:0] song_sel,
  output logic [2:0]        state_o
);

  localparam logic [SONG_W-1:0] LAST_SONG = SONG_W'(NUM_SONGS - 1);

  state_e              state;
  state_e              state_nx;
  logic [SONG_W-1:0]   sel_nx;
  logic [SONG_W-1:0]   sel_inc;
  logic [SONG_W-1:0]   sel_dec;
  logic [SONG_W-1:0]   sel_fwd;
  logic                play_nx;
  logic                reset_play_nx;
  logic                next_song_nx;

  // Explicit wrap keeps the index below NUM_SONGS for non-power-of-2 sizes
  assign sel_inc = (song_sel == LAST_SONG) ? '0 : song_sel + 1'b1;
  assign sel_dec = (song_sel == '0) ? LAST_SONG : song_sel - 1'b1;

`ifdef MCU_PLAYLIST_SHUFFLE_EN
  logic [7:0]        lfsr;
  logic [SONG_W:0]   rnd_raw;
  logic [SONG_W-1:0] rnd_pick;
  logic              unused_lfsr;

  mcu_lfsr8 u_lfsr (
    .clk   (clk),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign rnd_raw     = {1'b0, lfsr[SONG_W-1:0]};
  assign rnd_pick    = (rnd_raw >= (SONG_W+1)'(NUM_SONGS))
                     ? SONG_W'(rnd_raw - (SONG_W+1)'(NUM_SONGS))
                     : lfsr[SONG_W-1:0];
  assign sel_fwd     = (!shuffle)            ? sel_inc :
                       (rnd_pick == song_sel) ? sel_inc : rnd_pick;
  assign unused_lfsr = ^lfsr;
`else
  assign sel_fwd = sel_inc;
`endif

  always_comb begin
    state_nx = state;
    sel_nx   = song_sel;
    case (state)
      S_RESET: state_nx = S_PAUSE;
      S_PAUSE: begin
        if (play_pause) begin
          state_nx = S_PLAY;
        end else if (next) begin
          state_nx = S_LOAD;
          sel_nx   = sel_fwd;
        end else if (prev) begin
          state_nx = S_LOAD;
          sel_nx   = sel_dec;
        end
      end
      S_LOAD:  state_nx = S_PLAY;
      S_PLAY: begin
        if (play_pause) begin
          state_nx = S_PAUSE;
        end else if (next) begin
          state_nx = S_LOAD;
          sel_nx   = sel_fwd;
        end else if (prev) begin
          state_nx = S_LOAD;
          sel_nx   = sel_dec;
        end else if (song_done) begin
          case (mode)
            MODE_ONCE: begin
              if (song_sel == LAST_SONG) begin
                state_nx = S_STOP;
                sel_nx   = '0;
              end else begin
                state_nx = S_LOAD;
                sel_nx   = sel_fwd;
              end
            end
            MODE_REPEAT_ALL: begin
              state_nx = S_LOAD;
              sel_nx   = sel_fwd;
            end
            MODE_REPEAT_ONE: state_nx = S_LOAD;
            default:         state_nx = S_STOP;
          endcase
        end
      end
      S_STOP:  state_nx = S_PAUSE;
      default: state_nx = S_PAUSE;
    endcase

    // Outputs are registered alongside the state, so decode the next state
    play_nx       = (state_nx == S_PLAY);
    reset_play_nx = (state_nx == S_RESET) || (state_nx == S_LOAD) ||
                    (state_nx == S_STOP);
    next_song_nx  = (state_nx == S_LOAD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_RESET;
      song_sel   <= '0;
      play       <= 1'b0;
      reset_play <= 1'b1;
      next_song  <= 1'b0;
    end else begin
      state      <= state_nx;
      song_sel   <= sel_nx;
      play       <= play_nx;
      reset_play <= reset_play_nx;
      next_song  <= next_song_nx;
    end
  end

  assign state_o = state;

endmodule

`default_nettype wire

// File: tb/tb_mcu_playlist_ctrl.sv
// ============================================================================
// Module  : tb_mcu_playlist_ctrl
// Brief   : Self-checking bench for mcu_playlist_ctrl against a playlist model.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mcu_playlist_ctrl;

  localparam int N = 4;
  localparam int W = $clog2(N);

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         play_pause = 1'b0;
  logic         next = 1'b0;
  logic         prev = 1'b0;
  logic         song_done = 1'b0;
  logic [1:0]   mode = 2'b00;
  logic         play;
  logic         reset_play;
  logic         next_song;
  logic [W-1:0] song_sel;
  logic [2:0]   state_o;
`ifdef MCU_PLAYLIST_SHUFFLE_EN
  logic         shuffle = 1'b0;
`endif

  mcu_playlist_ctrl #(.NUM_SONGS(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .play_pause (play_pause),
    .next       (next),
    .prev       (prev),
    .song_done  (song_done),
`ifdef MCU_PLAYLIST_SHUFFLE_EN
    .shuffle    (shuffle),
`endif
    .mode       (mode),
    .play       (play),
    .reset_play (reset_play),
    .next_song  (next_song),
    .song_sel   (song_sel),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Playlist model: state codes 0 RESET,1 PAUSE,2 LOAD,3 PLAY,4 STOP
  int m_state = 0;
  int m_sel   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_sel   = 0;
  endtask

  task automatic model_step(input bit pp, input bit nx, input bit pv, input bit sd, input logic [1:0] md);
    case (m_state)
      0: m_state = 1;
      1, 3: begin
        if (pp) m_state = (m_state == 1) ? 3 : 1;
        else if (nx) begin m_state = 2; m_sel = (m_sel + 1) % N; end
        else if (pv) begin m_state = 2; m_sel = (m_sel + N - 1) % N; end
        else if (sd && m_state == 3) begin
          case (md)
            2'b00: if (m_sel == N - 1) begin m_state = 4; m_sel = 0; end
                   else begin m_state = 2; m_sel = m_sel + 1; end
            2'b01: begin m_state = 2; m_sel = (m_sel + 1) % N; end
            2'b10: m_state = 2;
            default: m_state = 4;
          endcase
        end
      end
      2: m_state = 3;
      default: m_state = 1;
    endcase
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".state"}, 32'(state_o), 32'(m_state));
    check({tag, ".play"}, 32'(play), 32'(m_state == 3));
    check({tag, ".reset_play"}, 32'(reset_play), 32'(m_state == 0 || m_state == 2 || m_state == 4));
    check({tag, ".next_song"}, 32'(next_song), 32'(m_state == 2));
    check({tag, ".song_sel"}, 32'(song_sel), 32'(m_sel));
  endtask

  // Apply one cycle of inputs, advance the model, check outputs #1 after the edge
  task automatic step(input string tag, input bit pp, input bit nx, input bit pv, input bit sd,
                      input logic [1:0] md, input bit use_model);
    play_pause = pp; next = nx; prev = pv; song_done = sd; mode = md;
    @(posedge clk);
    model_step(pp, nx, pv, sd, md);
    #1;
    play_pause = 0; next = 0; prev = 0; song_done = 0;
    if (use_model) compare_model(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  initial begin
    do_reset();
    check("rst.state", 32'(state_o), 32'd0);
    check("rst.play", 32'(play), 32'd0);
    check("rst.reset_play", 32'(reset_play), 32'd1);
    check("rst.next_song", 32'(next_song), 32'd0);
    check("rst.song_sel", 32'(song_sel), 32'd0);

    // Test 1: RESET -> PAUSE -> PLAY on play_pause
    step("t1a", 0, 0, 0, 0, 2'b00, 1);
    check("t1.pause", 32'(state_o), 32'd1);
    step("t1b", 0, 0, 0, 0, 2'b00, 1);
    step("t1c", 1, 0, 0, 0, 2'b00, 1);
    check("t1.play", 32'(play), 32'd1);
    check("t1.playstate", 32'(state_o), 32'd3);

    // Test 2: prev from 0 -> 3, then next from 3 wraps to 0
    step("t2a", 0, 0, 1, 0, 2'b00, 1);
    check("t2.prev_wrap", 32'(song_sel), 32'd3);
    step("t2b", 0, 0, 0, 0, 2'b00, 1);
    step("t2c", 0, 1, 0, 0, 2'b00, 1);
    check("t2.load_ns", 32'(next_song), 32'd1);
    check("t2.load_rp", 32'(reset_play), 32'd1);
    check("t2.next_wrap", 32'(song_sel), 32'd0);
    step("t2d", 0, 0, 0, 0, 2'b00, 1);
    check("t2.back_play", 32'(state_o), 32'd3);

    // Test 3: ONCE at last track -> STOP -> PAUSE, sel 0
    step("t3a", 0, 0, 1, 0, 2'b00, 1);
    step("t3b", 0, 0, 0, 0, 2'b00, 1);
    step("t3c", 0, 0, 0, 1, 2'b00, 1);
    check("t3.stop", 32'(state_o), 32'd4);
    check("t3.stop_sel", 32'(song_sel), 32'd0);
    step("t3d", 0, 0, 0, 0, 2'b00, 1);
    check("t3.pause_play", 32'(play), 32'd0);
    step("t3e", 0, 1, 0, 0, 2'b00, 1);
    step("t3f", 0, 0, 0, 0, 2'b00, 1);
    step("t3g", 0, 0, 0, 1, 2'b00, 1);
    check("t3.once_inc", 32'(song_sel), 32'd2);

    // Test 4: REPEAT_ONE keeps sel with next_song; SINGLE stops
    step("t4a", 0, 0, 0, 0, 2'b10, 1);
    step("t4b", 0, 0, 0, 1, 2'b10, 1);
    check("t4.rep1_ns", 32'(next_song), 32'd1);
    check("t4.rep1_sel", 32'(song_sel), 32'd2);
    step("t4c", 0, 0, 0, 0, 2'b11, 1);
    step("t4d", 0, 0, 0, 1, 2'b11, 1);
    check("t4.single_stop", 32'(state_o), 32'd4);
    check("t4.single_sel", 32'(song_sel), 32'd2);
    step("t4e", 0, 0, 0, 0, 2'b11, 1);
    step("t4f", 1, 0, 0, 0, 2'b11, 1);

    // Test 5: collisions
    step("t5a", 1, 1, 0, 1, 2'b01, 1);
    check("t5.pp_wins", 32'(state_o), 32'd1);
    check("t5.pp_sel", 32'(song_sel), 32'd2);
    step("t5b", 1, 0, 0, 0, 2'b01, 1);
    step("t5c", 0, 1, 1, 0, 2'b01, 1);
    check("t5.next_wins", 32'(song_sel), 32'd3);
    step("t5d", 0, 1, 0, 0, 2'b01, 1);
    check("t5.load_ignore", 32'(song_sel), 32'd3);

    // Test 6: asynchronous reset mid-LOAD
    step("t6a", 0, 1, 0, 0, 2'b01, 1);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("t6.async_state", 32'(state_o), 32'd0);
    check("t6.async_rp", 32'(reset_play), 32'd1);
    check("t6.async_ns", 32'(next_song), 32'd0);
    check("t6.async_sel", 32'(song_sel), 32'd0);
    #1 reset = 1'b0;

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        #2 reset = 1'b1;
        #1;
        model_reset();
        compare_model("rnd_rst");
        #1 reset = 1'b0;
      end else begin
        step("rnd", ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) == 0),
             2'($urandom_range(0, 3)), 1);
      end
    end

`ifdef MCU_PLAYLIST_SHUFFLE_EN
    do_reset();
    shuffle = 1'b1;
    step("sh0", 0, 0, 0, 0, 2'b01, 0);
    step("sh1", 1, 0, 0, 0, 2'b01, 0);
    for (int i = 0; i < 200; i++) begin
      int before;
      before = int'(song_sel);
      step("shd", 0, 0, 0, 1, 2'b01, 0);
      check("sh.range", 32'(song_sel < N), 32'd1);
      check("sh.no_repeat", 32'(int'(song_sel) != before), 32'd1);
      step("shp", 0, 0, 0, 0, 2'b01, 0);
    end
    shuffle = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mcu_playlist_ctrl.md
Name: mcu_playlist_ctrl

Overview:
Parametrised successor to the single-track player control FSM.
- Drives play/pause, skip-forward, skip-back and end-of-track handling across a playlist of NUM_SONGS tracks.
- Outputs the current track index to the song ROM address mux.
- Outputs play and reset_play to the note sequencer.
- Supports four end-of-track modes. Optional shuffle.

Parameters:
- NUM_SONGS, 4, number of tracks; legal range 2..16.
- SONG_W, $clog2(NUM_SONGS), width of the track index; derived, not overridden.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- play_pause  in  1  one-cycle pulse from debouncer; toggles play/pause
- next  in  1  one-cycle pulse; skip forward
- prev  in  1  one-cycle pulse; skip back
- song_done  in  1  one-cycle pulse from sequencer; current track finished
- mode  in  2  end-of-track mode: 00 ONCE, 01 REPEAT_ALL, 10 REPEAT_ONE, 11 SINGLE
- play  out  1  sequencer run enable
- reset_play  out  1  sequencer restart-from-beginning
- next_song  out  1  one-cycle pulse; song_sel has changed
- song_sel  out  SONG_W  current track index
- state_o  out  3  FSM state, for LED/debug

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high, on port reset. All outputs are registered.
- Reset values: state=RESET, play=0, reset_play=1, next_song=0, song_sel=0.
- States:
  - RESET: play=0, reset_play=1.
  - PAUSE: play=0, reset_play=0.
  - LOAD: play=0, reset_play=1, next_song=1.
  - PLAY: play=1, reset_play=0.
  - STOP: play=0, reset_play=1.
- Outputs change in the same clock edge as the state transition.
- Transitions:
  - RESET -> PAUSE unconditionally, after 1 cycle.
  - PAUSE:
    - play_pause -> PLAY.
    - else next -> LOAD, with song_sel = inc(song_sel).
    - else prev -> LOAD, with song_sel = dec(song_sel).
    - else hold.
  - LOAD -> PLAY unconditionally, after 1 cycle. All inputs in LOAD are ignored; pulses are dropped.
  - PLAY:
    - play_pause -> PAUSE.
    - else next -> LOAD, inc.
    - else prev -> LOAD, dec.
    - else song_done -> branch on mode, sampled that cycle:
      - ONCE: if song_sel==NUM_SONGS-1 -> STOP and song_sel=0; else LOAD, inc.
      - REPEAT_ALL: LOAD, inc.
      - REPEAT_ONE: LOAD, song_sel unchanged; next_song still pulses.
      - SINGLE: STOP, song_sel unchanged.
  - STOP -> PAUSE after 1 cycle.
  - song_done in PAUSE, RESET or STOP is ignored.
- Priority: play_pause > next > prev > song_done. If next and prev arrive in the same cycle, next wins.
- inc/dec wrap-around: inc(NUM_SONGS-1)=0; dec(0)=NUM_SONGS-1. This holds for non-power-of-2 NUM_SONGS; the index never takes a value >= NUM_SONGS.
- Illegal state encodings -> PAUSE with all outputs at PAUSE values.
- reset asserted in any state, including LOAD, returns to reset values immediately, without waiting for a clock edge.
- state_o encoding: RESET=0, PAUSE=1, LOAD=2, PLAY=3, STOP=4.

Optional Feature:
MCU_PLAYLIST_SHUFFLE_EN
- Defined:
  - Adds input port shuffle (1 bit).
  - Adds an 8-bit Fibonacci LFSR (taps 8,6,5,4), seed 8'h01 on reset, advancing every cycle.
  - When shuffle=1, every inc in the transition rules is replaced by a pseudo-random pick: r = lfsr[SONG_W-1:0]; if r>=NUM_SONGS then r=r-NUM_SONGS. If r==song_sel, use inc(song_sel).
  - prev, REPEAT_ONE and the ONCE end-of-list test are unaffected.
- Undefined: no shuffle port, no LFSR; purely sequential.

Decomposition:
- Package mcu_pkg holds:
  - state localparams RESET/PAUSE/LOAD/PLAY/STOP (3-bit);
  - mode encodings MODE_ONCE/MODE_REPEAT_ALL/MODE_REPEAT_ONE/MODE_SINGLE;
  - LFSR seed and tap constants.
- Sub-module mcu_lfsr8: free-running LFSR with async reset. Instantiated only under MCU_PLAYLIST_SHUFFLE_EN.

Test Plan:
1. Reset release, then play_pause pulse at cycle 3 -> state_o 0->1->3; play=1 at cycle 4; song_sel=0.
2. NUM_SONGS=4, PLAY, song_sel=3, next pulse -> LOAD for 1 cycle with next_song=1 and reset_play=1, song_sel=0, then PLAY. prev from song_sel=0 -> song_sel=3.
3. mode=ONCE, song_sel=3, song_done -> STOP 1 cycle, then PAUSE, song_sel=0, play=0. With song_sel=1 -> LOAD, song_sel=2.
4. mode=REPEAT_ONE, song_sel=2, song_done -> LOAD with next_song=1, song_sel stays 2, then PLAY. mode=SINGLE -> STOP, song_sel stays 2.
5. Same-cycle collisions in PLAY:
   - play_pause+next+song_done -> PAUSE, song_sel unchanged.
   - next+prev -> song_sel+1.
   - next during LOAD -> ignored.
6. reset asserted mid-LOAD, between clock edges -> outputs take reset values before the next edge. With MCU_PLAYLIST_SHUFFLE_EN and shuffle=1: 200 song_done pulses in REPEAT_ALL -> song_sel always <NUM_SONGS, never repeats back-to-back.
